beam_topk_sort: RTL and testbench

// - Parametrised top-K beam selector: accepts one vector of COL unsigned beam powers, ranks every beam
//   (largest first, ties by lower index), streams the K strongest as (power, beam index) pairs.
// - Time-multiplexed ranking: LANES beams ranked per cycle; frees area vs. a fully parallel compare array.
// - Sits after beam power computation, feeds the dimension-reduction beam selection stage.

---
 rtl/beam_topk_sort_if.sv | 38 +++
 rtl/beam_topk_sort.sv | 160 ++++++++++++++++
 tb/tb_beam_topk_sort.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/beam_topk_sort_if.sv
// Beam top-K selector bus: input vector handshake, ranked beat stream, optional top-K mask.
// Latency: wiring only. Backpressure: vector side uses i_rvalid/o_rready; beat side uses o_tvalid/i_tready.
// o_tmask is present only when BEAM_TOPK_MASK_EN is defined.
interface beam_topk_sort_if #(
    parameter int IW   = 32,
    parameter int COL  = 64,
    parameter int IDXW = (COL > 1) ? $clog2(COL) : 1
);
    logic [COL-1:0][IW-1:0] i_data;
    logic                   i_rvalid;
    logic                   o_rready;
    logic [IW-1:0]          o_tdata;
    logic [IDXW-1:0]        o_tindex;
    logic [IDXW-1:0]        o_trank;
    logic                   o_tvalid;
    logic                   i_tready;
    logic                   o_tlast;
    logic                   o_busy;
`ifdef BEAM_TOPK_MASK_EN
    logic [COL-1:0]         o_tmask;
`endif

    modport master (
`ifdef BEAM_TOPK_MASK_EN
        input  o_tmask,
`endif
        output i_data, i_rvalid, i_tready,
        input  o_rready, o_tdata, o_tindex, o_trank, o_tvalid, o_tlast, o_busy
    );

    modport slave (
`ifdef BEAM_TOPK_MASK_EN
        output o_tmask,
`endif
        input  i_data, i_rvalid, i_tready,
        output o_rready, o_tdata, o_tindex, o_trank, o_tvalid, o_tlast, o_busy
    );
endinterface

// File: rtl/beam_topk_sort.sv
// Top-K beam selector: ranks COL beam powers LANES per cycle, streams the TOPK strongest (optional BEAM_TOPK_MASK_EN mask).
// Latency: accept edge T -> first beat valid after edge T+COL/LANES+2; one vector in flight at a time.
// Backpressure: beats advance only on o_tvalid&&i_tready, payload held while stalled; o_rready low until the last beat leaves.
module beam_topk_sort #(
    parameter int IW    = 32,
    parameter int COL   = 64,
    parameter int TOPK  = 16,
    parameter int LANES = 8
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    beam_topk_sort_if.slave bus
);
    localparam int IDXW = (COL > 1) ? $clog2(COL) : 1;
    localparam int NCYC = COL / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [IDXW:0] LAST_W   = (IDXW+1)'(TOPK - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(NCYC - 1);

    if (COL % LANES != 0) begin : g_bad_lanes
        $error("beam_topk_sort: COL must be a multiple of LANES");
    end
    if (TOPK < 1 || TOPK > COL) begin : g_bad_topk
        $error("beam_topk_sort: TOPK must lie in 1..COL");
    end

    typedef enum logic [1:0] {S_IDLE, S_RANK, S_SCATTER, S_EMIT} state_t;
    state_t state_q, state_d;

    logic [COL-1:0][IW-1:0] d_q;
    logic [IDXW:0]          rank_q       [COL];
    logic [IW-1:0]          sorted_dat_q [COL];
    logic [IDXW-1:0]        sorted_idx_q [COL];
    logic [CW-1:0]          cyc_q;
    logic [IDXW-1:0]        beat_q, sel_beat;
    logic                   tvalid_q, tlast_q;
    logic [IW-1:0]          tdata_q;
    logic [IDXW-1:0]        tindex_q, trank_q;
    logic [IDXW:0]          lane_idx  [LANES];
    logic [IDXW:0]          lane_rank [LANES];
    logic [IW-1:0]          lane_val  [LANES];
    logic                   last_hs;

    // Rank = beams strictly stronger + equal beams with lower index, so ranks are a permutation.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l]  = (IDXW+1)'(cyc_q) * (IDXW+1)'(LANES) + (IDXW+1)'(l);
            lane_val[l]  = d_q[lane_idx[l][IDXW-1:0]];
            lane_rank[l] = '0;
            for (int j = 0; j < COL; j++) begin
                if ((d_q[j] > lane_val[l]) ||
                    ((d_q[j] == lane_val[l]) && ((IDXW+1)'(j) < lane_idx[l]))) begin
                    lane_rank[l] = lane_rank[l] + (IDXW+1)'(1);
                end
            end
        end
    end

    assign last_hs  = tvalid_q && bus.i_tready && ({1'b0, beat_q} == LAST_W);
    assign sel_beat = tvalid_q ? beat_q + IDXW'(1) : beat_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.i_rvalid) state_d = S_RANK;
            S_RANK:    if (cyc_q == CYC_LAST) state_d = S_SCATTER;
            S_SCATTER: state_d = S_EMIT;
            S_EMIT:    if (last_hs) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            d_q      <= '0;
            cyc_q    <= '0;
            beat_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tindex_q <= '0;
            trank_q  <= '0;
            for (int i = 0; i < COL; i++) begin
                rank_q[i]       <= '0;
                sorted_dat_q[i] <= '0;
                sorted_idx_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    cyc_q <= '0;
                    if (bus.i_rvalid) d_q <= bus.i_data;
                end
                S_RANK: begin
                    cyc_q <= cyc_q + CW'(1);
                    for (int l = 0; l < LANES; l++) rank_q[lane_idx[l][IDXW-1:0]] <= lane_rank[l];
                end
                S_SCATTER: begin
                    beat_q <= '0;
                    for (int i = 0; i < COL; i++) begin
                        for (int n = 0; n < COL; n++) begin
                            if (rank_q[i] == (IDXW+1)'(n)) begin
                                sorted_dat_q[n] <= d_q[i];
                                sorted_idx_q[n] <= IDXW'(i);
                            end
                        end
                    end
                end
                S_EMIT: begin
                    // First EMIT cycle loads beat 0 into the output register; afterwards load on handshake.
                    if (last_hs) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        tdata_q  <= '0;
                        tindex_q <= '0;
                        trank_q  <= '0;
                    end else if (!tvalid_q || bus.i_tready) begin
                        tvalid_q <= 1'b1;
                        beat_q   <= sel_beat;
                        tdata_q  <= sorted_dat_q[sel_beat];
                        tindex_q <= sorted_idx_q[sel_beat];
                        trank_q  <= sel_beat;
                        tlast_q  <= ({1'b0, sel_beat} == LAST_W);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BEAM_TOPK_MASK_EN
    localparam logic [IDXW:0] TOPK_W = (IDXW+1)'(TOPK);
    logic [COL-1:0] mask_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mask_q <= '0;
        end else if (state_q == S_SCATTER) begin
            for (int i = 0; i < COL; i++) mask_q[i] <= (rank_q[i] < TOPK_W);
        end else if (state_q == S_EMIT && state_d == S_IDLE) begin
            mask_q <= '0;
        end
    end

    assign bus.o_tmask = mask_q;
`endif

    assign bus.o_rready = (state_q == S_IDLE);
    assign bus.o_busy   = (state_q != S_IDLE);
    assign bus.o_tvalid = tvalid_q;
    assign bus.o_tlast  = tlast_q;
    assign bus.o_tdata  = tdata_q;
    assign bus.o_tindex = tindex_q;
    assign bus.o_trank  = trank_q;
endmodule

// File: tb/tb_beam_topk_sort.sv
// Bench for beam_topk_sort: table-driven vectors, hand-written reset sequences, random vectors vs a selection-sort model.
module tb_beam_topk_sort;
    localparam int IW    = 32;
    localparam int COL   = 64;
    localparam int TOPK  = 16;
    localparam int LANES = 8;
    localparam int IDXW  = 6;
    localparam int NCYC  = COL / LANES;

    typedef logic [COL-1:0][IW-1:0] vec_t;
    typedef struct {
        int            kind;
        int            rdy_pct;
        int            pos [3];
        logic [IW-1:0] dat [3];
        int            idx [3];
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [IW-1:0]  exp_dat [COL];
    int             exp_idx [COL];
    logic [COL-1:0] exp_mask;
    logic [IW-1:0]  got_dat [TOPK];
    int             got_idx [TOPK];
    rec_t           tbl [5];

    beam_topk_sort_if #(.IW(IW), .COL(COL), .IDXW(IDXW)) bif ();

    beam_topk_sort #(.IW(IW), .COL(COL), .TOPK(TOPK), .LANES(LANES)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bif.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t make_vec(input int kind);
        vec_t d;
        logic [7:0] pat [16] = '{8'h11, 8'h12, 8'h03, 8'h04, 8'h15, 8'h16, 8'h07, 8'h08,
                                 8'h19, 8'h1A, 8'h0B, 8'h0C, 8'h0D, 8'h1E, 8'h01, 8'h01};
        for (int b = 0; b < COL; b++) begin
            case (kind)
                0:       d[b] = IW'(b + 1);
                1:       d[b] = IW'(pat[b % 16]);
                2:       d[b] = IW'(7);
                3:       d[b] = '0;
                4:       d[b] = IW'(1000 - b);
                5:       d[b] = $urandom;
                6:       d[b] = IW'($urandom_range(0, 7));
                default: d[b] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : IW'($urandom_range(0, 2));
            endcase
        end
        return d;
    endfunction

    // Reference: repeatedly pick the strongest remaining beam; strict '>' keeps the lowest index on ties.
    task automatic model(input vec_t d);
        bit used [COL];
        int best;
        for (int b = 0; b < COL; b++) used[b] = 1'b0;
        exp_mask = '0;
        for (int n = 0; n < COL; n++) begin
            best = -1;
            for (int b = 0; b < COL; b++)
                if (!used[b] && (best < 0 || d[b] > d[best])) best = b;
            used[best] = 1'b1;
            exp_dat[n] = d[best];
            exp_idx[n] = best;
            if (n < TOPK) exp_mask[best] = 1'b1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " tvalid"}, 64'(bif.o_tvalid), 64'(0));
        check({tag, " rready"}, 64'(bif.o_rready), 64'(1));
        check({tag, " busy"},   64'(bif.o_busy),   64'(0));
        check({tag, " tlast"},  64'(bif.o_tlast),  64'(0));
        check({tag, " tdata"},  64'(bif.o_tdata),  64'(0));
        check({tag, " tindex"}, 64'(bif.o_tindex), 64'(0));
        check({tag, " trank"},  64'(bif.o_trank),  64'(0));
`ifdef BEAM_TOPK_MASK_EN
        check({tag, " tmask"},  64'(bif.o_tmask),  64'(0));
`endif
    endtask

    // Called at 1 ns after a rising edge; returns at 1 ns after the edge of the last handshake.
    task automatic run_vec(input vec_t d, input int rdy_pct, input string tag);
        int            cyc;
        int            n;
        int            budget;
        logic          stalled;
        logic [IW-1:0] s_dat;
        logic [IDXW-1:0] s_idx, s_rank;
        logic          s_last;
        model(d);
        cyc = 0;
        while (!bif.o_rready && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, " ready before accept"}, 64'(bif.o_rready), 64'(1));
        bif.i_data   = d;
        bif.i_rvalid = 1'b1;
        @(posedge clk); #1;
        bif.i_rvalid = 1'b0;
        bif.i_data   = make_vec(5);
        check({tag, " busy after accept"}, 64'(bif.o_busy), 64'(1));
        check({tag, " rready after accept"}, 64'(bif.o_rready), 64'(0));
        cyc = 0;
        while (!bif.o_tvalid && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(NCYC + 2));
        n = 0;
        stalled = 1'b0;
        budget = 2000;
        s_dat = '0; s_idx = '0; s_rank = '0; s_last = 1'b0;
        while (n < TOPK && budget > 0) begin
            bif.i_tready = ($urandom_range(0, 99) < rdy_pct);
            check({tag, " tvalid held"}, 64'(bif.o_tvalid), 64'(1));
            if (bif.o_tvalid) begin
`ifdef BEAM_TOPK_MASK_EN
                check({tag, " tmask"}, 64'(bif.o_tmask), 64'(exp_mask));
`endif
                if (stalled) begin
                    check({tag, " stall tdata"},  64'(bif.o_tdata),  64'(s_dat));
                    check({tag, " stall tindex"}, 64'(bif.o_tindex), 64'(s_idx));
                    check({tag, " stall trank"},  64'(bif.o_trank),  64'(s_rank));
                    check({tag, " stall tlast"},  64'(bif.o_tlast),  64'(s_last));
                end
                if (bif.i_tready) begin
                    check({tag, " tdata"},  64'(bif.o_tdata),  64'(exp_dat[n]));
                    check({tag, " tindex"}, 64'(bif.o_tindex), 64'(exp_idx[n]));
                    check({tag, " trank"},  64'(bif.o_trank),  64'(n));
                    check({tag, " tlast"},  64'(bif.o_tlast),  64'(n == TOPK - 1));
                    got_dat[n] = bif.o_tdata;
                    got_idx[n] = int'(bif.o_tindex);
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    s_dat = bif.o_tdata; s_idx = bif.o_tindex;
                    s_rank = bif.o_trank; s_last = bif.o_tlast;
                end
            end
            @(posedge clk); #1;
            budget--;
        end
        if (n < TOPK) check({tag, " beats before timeout"}, 64'(n), 64'(TOPK));
        bif.i_tready = 1'b0;
        check_idle({tag, " after last beat"});
    endtask

    task automatic pulse_reset_and_check(input string tag);
        #2 rst_n = 1'b0;
        #1 check_idle(tag);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check({tag, " no partial output"}, 64'(bif.o_tvalid), 64'(0));
        end
    endtask

    function automatic rec_t mk_rec(input int kind, input int rdy,
                                    input int p0, input int d0, input int i0,
                                    input int p1, input int d1, input int i1,
                                    input int p2, input int d2, input int i2);
        rec_t r;
        r.kind = kind; r.rdy_pct = rdy;
        r.pos[0] = p0; r.dat[0] = IW'(d0); r.idx[0] = i0;
        r.pos[1] = p1; r.dat[1] = IW'(d1); r.idx[1] = i1;
        r.pos[2] = p2; r.dat[2] = IW'(d2); r.idx[2] = i2;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk_rec(0, 100, 0, 64, 63,     4, 60, 59,      15, 49, 48);
        tbl[1] = mk_rec(1, 50,  3, 'h1E, 61,   4, 'h1A, 9,     15, 'h16, 53);
        tbl[2] = mk_rec(2, 100, 0, 7, 0,       4, 7, 4,        15, 7, 15);
        tbl[3] = mk_rec(3, 50,  0, 0, 0,       4, 0, 4,        15, 0, 15);
        tbl[4] = mk_rec(4, 100, 0, 1000, 0,    4, 996, 4,      15, 985, 15);

        // Reset held with inputs toggling.
        bif.i_data   = make_vec(5);
        bif.i_rvalid = 1'b1;
        bif.i_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bif.i_data   = make_vec(5);
            bif.i_tready = k[0];
            check_idle("in reset");
        end
        bif.i_rvalid = 1'b0;
        bif.i_tready = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("after reset");

        for (int t = 0; t < 5; t++) begin
            run_vec(make_vec(tbl[t].kind), tbl[t].rdy_pct, $sformatf("table%0d", t));
            for (int c = 0; c < 3; c++) begin
                check($sformatf("table%0d beat%0d data", t, tbl[t].pos[c]),
                      64'(got_dat[tbl[t].pos[c]]), 64'(tbl[t].dat[c]));
                check($sformatf("table%0d beat%0d index", t, tbl[t].pos[c]),
                      64'(got_idx[tbl[t].pos[c]]), 64'(tbl[t].idx[c]));
            end
        end

        // Reset in the middle of RANK.
        bif.i_data   = make_vec(0);
        bif.i_rvalid = 1'b1;
        @(posedge clk); #1;
        bif.i_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("mid-rank busy", 64'(bif.o_busy), 64'(1));
        pulse_reset_and_check("reset mid-rank");
        run_vec(make_vec(6), 100, "after rank reset");

        // Reset in the middle of EMIT, downstream stalled.
        bif.i_tready = 1'b0;
        bif.i_data   = make_vec(4);
        bif.i_rvalid = 1'b1;
        @(posedge clk); #1;
        bif.i_rvalid = 1'b0;
        repeat (NCYC + 4) @(posedge clk);
        #1 check("mid-emit tvalid", 64'(bif.o_tvalid), 64'(1));
        check("mid-emit tdata", 64'(bif.o_tdata), 64'(1000));
        pulse_reset_and_check("reset mid-emit");
        run_vec(make_vec(1), 50, "after emit reset");

        for (int r = 0; r < 6; r++)
            run_vec(make_vec(5 + (r % 3)), (r < 3) ? 50 : 100, $sformatf("random%0d", r));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
